seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the hex-to-segment encoder.
- Monitors a time-multiplexed 7-segment display bus (segment lines plus per-digit enables) and decodes each digit's pattern back into a 4-bit nibble.
- Assembles one full frame into a hex word and presents it through a VALID/ACK handshake.
- Used for display readback and self-test of the LED path on the board.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_scan_capture_if.sv | 24 ++
 rtl/seg7_to_nibble.sv | 39 +++
 rtl/seg7_scan_capture.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table and common types.
// Used by both the hex encoder and the scan-capture receiver.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F_IDX = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_ALL = 7'((1 << SEG_A) | (1 << SEG_B) |
                                        (1 << SEG_C) | (1 << SEG_D) |
                                        (1 << SEG_E) | (1 << SEG_F_IDX) |
                                        (1 << SEG_G));

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = SEG_ALL;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_A_GLY = 7'h77;
    localparam logic [6:0] SEG_B_GLY = 7'h7C;
    localparam logic [6:0] SEG_C_GLY = 7'h58;
    localparam logic [6:0] SEG_D_GLY = 7'h5E;
    localparam logic [6:0] SEG_E_GLY = 7'h79;
    localparam logic [6:0] SEG_F_GLY = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_FULL
    } out_state_e;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display bus and frame handshake bundle for the scan-capture block.
// master drives the display/ACK side, slave is the capture block.
interface seg7_scan_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        SEGLED;
    logic [NDIG-1:0]   DIGEN;
    logic              ACK;
    logic              VALID;
    logic [4*NDIG-1:0] WORD;
    logic [NDIG-1:0]   DIGERR;
    logic [NDIG-1:0]   BLANK;
    logic              OVERRUN;

    modport master (
        output SEGLED, DIGEN, ACK,
        input  VALID, WORD, DIGERR, BLANK, OVERRUN
    );

    modport slave (
        input  SEGLED, DIGEN, ACK,
        output VALID, WORD, DIGERR, BLANK, OVERRUN
    );
endinterface

// File: rtl/seg7_to_nibble.sv
// Combinational segment-pattern to hex nibble decoder.
// Unknown patterns decode to 0 with err set; all-off is blank.
module seg7_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       err_o,
    output logic       blank_o
);

    // Glyph lookup against the shared table
    always_comb begin
        nib_o   = 4'h0;
        err_o   = 1'b0;
        blank_o = 1'b0;
        unique case (seg_i)
            SEG_0:     nib_o = 4'h0;
            SEG_1:     nib_o = 4'h1;
            SEG_2:     nib_o = 4'h2;
            SEG_3:     nib_o = 4'h3;
            SEG_4:     nib_o = 4'h4;
            SEG_5:     nib_o = 4'h5;
            SEG_6:     nib_o = 4'h6;
            SEG_7:     nib_o = 4'h7;
            SEG_8:     nib_o = 4'h8;
            SEG_9:     nib_o = 4'h9;
            SEG_A_GLY: nib_o = 4'hA;
            SEG_B_GLY: nib_o = 4'hB;
            SEG_C_GLY: nib_o = 4'hC;
            SEG_D_GLY: nib_o = 4'hD;
            SEG_E_GLY: nib_o = 4'hE;
            SEG_F_GLY: nib_o = 4'hF;
            SEG_BLANK: blank_o = 1'b1;
            default:   err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Multiplexed 7-segment bus receiver: captures each stable digit,
// assembles a frame and presents it over VALID/ACK.
module seg7_scan_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8
) (
    input logic CLK,
    input logic RST_N,
    seg7_scan_capture_if.slave bus
);
    import seg7_pkg::*;

    localparam logic [CNT_W-1:0] CAP_AT = CNT_W'(STABLE_CYC - 1);

    logic [6:0]        seg_q, seg_p_q;
    logic [NDIG-1:0]   dig_q, dig_p_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cap_q, cap_d;
    logic              onehot, stable, capture;
    logic [3:0]        dec_nib;
    logic              dec_err, dec_blank;
    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] work_nib_q, work_nib_d;
    logic [NDIG-1:0]   work_err_q, work_err_d;
    logic [NDIG-1:0]   work_blank_q, work_blank_d;
    logic              complete, ack, ovr_set;
    out_state_e        state_q;
    logic [4*NDIG-1:0] word_q;
    logic [NDIG-1:0]   err_q, blank_q;
    logic              ovr_q;

    assign ack = bus.ACK;

    // Register the display bus once, keeping the previous sample too
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            seg_q   <= '0;
            seg_p_q <= '0;
            dig_q   <= '0;
            dig_p_q <= '0;
        end else begin
            seg_q   <= bus.SEGLED;
            seg_p_q <= seg_q;
            dig_q   <= bus.DIGEN;
            dig_p_q <= dig_q;
        end
    end

    seg7_to_nibble u_dec (
        .seg_i   (seg_q),
        .nib_o   (dec_nib),
        .err_o   (dec_err),
        .blank_o (dec_blank)
    );

    // Dwell tracking: cnt_d counts repeats of the current sample
    always_comb begin
        onehot = (dig_q != '0) &&
                 ((dig_q & (dig_q - 1'b1)) == '0);
        stable = onehot && (seg_q == seg_p_q) &&
                 (dig_q == dig_p_q);
        cnt_d  = '0;
        cap_d  = 1'b0;
        if (stable) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            cap_d = cap_q;
        end
        capture = onehot && (cnt_d == CAP_AT) && !cap_d;
        cap_d   = cap_d | capture;
    end

    // Stability counter and one-capture-per-dwell flag
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
            cap_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cap_q <= cap_d;
        end
    end

    // Working frame update; a capture beats the completion clear
    always_comb begin
        complete     = (seen_q == '1);
        seen_d       = complete ? '0 : seen_q;
        work_nib_d   = work_nib_q;
        work_err_d   = work_err_q;
        work_blank_d = work_blank_q;
        if (capture) begin
            seen_d = seen_d | dig_q;
            for (int i = 0; i < NDIG; i++) begin
                if (dig_q[i]) begin
                    work_nib_d[i*4 +: 4] = dec_nib;
                    work_err_d[i]        = dec_err;
                    work_blank_d[i]      = dec_blank;
                end
            end
        end
        ovr_set = complete && (state_q == ST_FULL) && !ack;
    end

    // Seen mask and working frame storage
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            seen_q       <= '0;
            work_nib_q   <= '0;
            work_err_q   <= '0;
            work_blank_q <= '0;
        end else begin
            seen_q       <= seen_d;
            work_nib_q   <= work_nib_d;
            work_err_q   <= work_err_d;
            work_blank_q <= work_blank_d;
        end
    end

    // Output handshake FSM with registered frame and sticky overrun
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            err_q   <= '0;
            blank_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= ovr_set || (ovr_q && !ack);
            unique case (state_q)
                ST_IDLE: begin
                    if (complete) begin
                        state_q <= ST_FULL;
                        word_q  <= work_nib_q;
                        err_q   <= work_err_q;
                        blank_q <= work_blank_q;
                    end
                end
                ST_FULL: begin
                    if (complete && ack) begin
                        word_q  <= work_nib_q;
                        err_q   <= work_err_q;
                        blank_q <= work_blank_q;
                    end else if (!complete && ack) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.VALID   = (state_q == ST_FULL);
    assign bus.WORD    = word_q;
    assign bus.DIGERR  = err_q;
    assign bus.BLANK   = blank_q;
    assign bus.OVERRUN = ovr_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: directed scenarios
// followed by randomized scanning against a dwell-level model.
module tb_seg7_scan_capture;

    localparam int NDIG = 4;
    localparam int SC   = 8;

    localparam logic [6:0] GLY [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [15:0] word;
        logic [3:0]  err;
        logic [3:0]  blank;
    } frame_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    seg7_scan_capture_if #(.NDIG(NDIG)) bus ();

    seg7_scan_capture #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass = 0;
    frame_t exp_q[$];

    logic        m_valid, m_ovr, comp_pend, cap_pend;
    logic [3:0]  m_seen, m_err, m_blank, prev_dig;
    logic [15:0] m_word;
    logic [6:0]  prev_seg;
    int          run, cap_slot;
    logic [3:0]  cap_nib;
    logic        cap_e, cap_b;
    logic        mon_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    function automatic void dec(input logic [6:0] s, output logic [3:0] n,
                                output logic e, output logic b);
        n = 4'h0;
        e = 1'b0;
        b = 1'b0;
        if (s == 7'h00) begin
            b = 1'b1;
            return;
        end
        for (int k = 0; k < 16; k++)
            if (GLY[k] == s) begin
                n = 4'(k);
                return;
            end
        e = 1'b1;
    endfunction

    // One model step per clock edge, using the values sampled there
    task automatic model_step(input logic [6:0] seg, input logic [3:0] dig,
                              input logic ack, input logic rst_n);
        logic vb, ns, oh;
        if (!rst_n) begin
            m_valid = 0; m_ovr = 0; m_seen = 0; m_word = 0;
            m_err = 0; m_blank = 0; run = 0; prev_seg = 0;
            prev_dig = 0; cap_pend = 0; comp_pend = 0;
            return;
        end
        vb = m_valid;
        ns = 1'b0;
        if (comp_pend) begin
            if (!vb || ack) begin
                exp_q.push_back('{m_word, m_err, m_blank});
                m_valid = 1'b1;
            end else begin
                ns = 1'b1;
            end
            m_seen = 4'h0;
        end else if (vb && ack) begin
            m_valid = 1'b0;
        end
        m_ovr = ns || (m_ovr && !ack);
        if (cap_pend) begin
            m_word[cap_slot*4 +: 4] = cap_nib;
            m_err[cap_slot]   = cap_e;
            m_blank[cap_slot] = cap_b;
            m_seen[cap_slot]  = 1'b1;
        end
        comp_pend = (m_seen == 4'hF);
        cap_pend = 1'b0;
        oh = ($countones(dig) == 1);
        if (oh && seg == prev_seg && dig == prev_dig) run++;
        else run = oh ? 1 : 0;
        prev_seg = seg;
        prev_dig = dig;
        if (run == SC) begin
            cap_pend = 1'b1;
            for (int k = 0; k < NDIG; k++) if (dig[k]) cap_slot = k;
            dec(seg, cap_nib, cap_e, cap_b);
        end
    endtask

    task automatic cyc(input logic [6:0] seg, input logic [3:0] dig,
                       input logic ack);
        bus.SEGLED = seg;
        bus.DIGEN  = dig;
        bus.ACK    = ack;
        @(posedge CLK);
        model_step(seg, dig, ack, RST_N);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        repeat (n) cyc(s, 4'(1 << d), 1'b0);
    endtask

    task automatic idle(input int n, input logic ack);
        repeat (n) cyc(7'h00, 4'h0, ack);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input int n);
        show(0, s0, n);
        show(1, s1, n);
        show(2, s2, n);
        show(3, s3, n);
    endtask

    // Monitor: pops the scoreboard whenever a frame is newly presented
    initial begin
        logic        last_valid, last_acc;
        logic [15:0] held;
        frame_t      f;
        last_valid = 1'b0;
        last_acc   = 1'b0;
        held       = 16'h0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                chk("valid", 32'(bus.VALID), 32'(m_valid));
                chk("overrun", 32'(bus.OVERRUN), 32'(m_ovr));
                if (bus.VALID && (!last_valid || last_acc)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame_unexpected: got %h expected none",
                                 bus.WORD);
                    end else begin
                        f = exp_q.pop_front();
                        chk("frame_word", 32'(bus.WORD), 32'(f.word));
                        chk("frame_err", 32'(bus.DIGERR), 32'(f.err));
                        chk("frame_blank", 32'(bus.BLANK), 32'(f.blank));
                    end
                    held = bus.WORD;
                end else if (bus.VALID) begin
                    chk("frame_hold", 32'(bus.WORD), 32'(held));
                end
                last_valid = bus.VALID;
                last_acc   = bus.VALID && bus.ACK;
            end
        end
    end

    initial begin
        logic [6:0] s;
        logic [3:0] dg;
        logic       a;
        int         r;
        RST_N = 1'b0;
        repeat (3) cyc(7'($urandom), 4'($urandom), 1'b0);
        RST_N = 1'b1;
        mon_en = 1'b1;
        chk("rst_valid", 32'(bus.VALID), 0);
        chk("rst_word", 32'(bus.WORD), 0);
        chk("rst_err", 32'(bus.DIGERR), 0);
        chk("rst_blank", 32'(bus.BLANK), 0);
        chk("rst_ovr", 32'(bus.OVERRUN), 0);

        frame(7'h5B, 7'h66, 7'h7C, 7'h71, 20);
        idle(4, 1'b0);
        chk("clean_valid", 32'(bus.VALID), 1);
        chk("clean_word", 32'(bus.WORD), 32'h0000_FB42);
        chk("clean_err", 32'(bus.DIGERR), 0);
        chk("clean_blank", 32'(bus.BLANK), 0);
        idle(1, 1'b1);
        chk("clean_ack", 32'(bus.VALID), 0);

        show(0, 7'h5B, 10);
        show(2, 7'h7C, 10);
        show(3, 7'h71, 10);
        show(1, 7'h66, 5);
        cyc(7'h66, 4'b0011, 1'b0);
        idle(4, 1'b0);
        chk("short_dwell", 32'(bus.VALID), 0);
        show(1, 7'h66, SC);
        idle(3, 1'b0);
        chk("dwell_ok", 32'(bus.VALID), 1);
        chk("dwell_word", 32'(bus.WORD), 32'h0000_FB42);
        idle(1, 1'b1);

        frame(7'h00, 7'h3F, 7'h12, 7'h7F, 12);
        idle(3, 1'b0);
        chk("bad_word", 32'(bus.WORD), 32'h0000_8000);
        chk("bad_blank", 32'(bus.BLANK), 32'h1);
        chk("bad_err", 32'(bus.DIGERR), 32'h4);
        idle(1, 1'b1);

        frame(7'h06, 7'h5B, 7'h4F, 7'h66, 12);
        frame(7'h6D, 7'h7D, 7'h07, 7'h7F, 12);
        idle(3, 1'b0);
        chk("ovr_set", 32'(bus.OVERRUN), 1);
        chk("ovr_word", 32'(bus.WORD), 32'h0000_4321);
        idle(1, 1'b1);
        chk("ovr_clr", 32'(bus.OVERRUN), 0);
        chk("ovr_valid", 32'(bus.VALID), 0);

        frame(7'h06, 7'h5B, 7'h4F, 7'h66, 12);
        idle(2, 1'b0);
        show(0, 7'h67, 12);
        show(1, 7'h77, 12);
        show(2, 7'h58, 12);
        show(3, 7'h5E, SC);
        cyc(7'h5E, 4'b1000, 1'b0);
        cyc(7'h5E, 4'b1000, 1'b1);
        chk("sim_valid", 32'(bus.VALID), 1);
        chk("sim_word", 32'(bus.WORD), 32'h0000_DCA9);
        chk("sim_ovr", 32'(bus.OVERRUN), 0);
        idle(1, 1'b1);

        show(0, 7'h79, 12);
        show(1, 7'h71, 12);
        idle(2, 1'b0);
        RST_N = 1'b0;
        idle(2, 1'b0);
        RST_N = 1'b1;
        show(2, 7'h06, 12);
        show(3, 7'h5B, 12);
        idle(3, 1'b0);
        chk("rst_partial", 32'(bus.VALID), 0);
        show(0, 7'h4F, 12);
        show(1, 7'h66, 12);
        idle(3, 1'b0);
        chk("rst_frame_v", 32'(bus.VALID), 1);
        chk("rst_frame_w", 32'(bus.WORD), 32'h0000_2143);
        idle(1, 1'b1);

        for (int f = 0; f < 250; f++) begin
            r  = $urandom_range(0, 9);
            s  = (r == 0) ? 7'h00 :
                 (r == 1) ? 7'($urandom) : GLY[$urandom_range(0, 15)];
            dg = 4'(1 << $urandom_range(0, 3));
            for (int c = 0; c < int'($urandom_range(3, 14)); c++) begin
                a = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 30) == 0)
                    cyc(7'($urandom), dg, a);
                else if ($urandom_range(0, 40) == 0)
                    cyc(s, 4'($urandom), a);
                else
                    cyc(s, dg, a);
            end
        end
        idle(6, 1'b1);
        idle(2, 1'b0);
        chk("drain", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
